ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipelined CPU. Sits directly downstream of the decode stage and upstream of the memory stage. Holds the ID/EX pipeline register, latching the decoded control signals, operands and instruction tags on every clock. From the registered values it computes the ALU result, destination register, branch target and branch-taken decision for the memory stage.

## Interface
Parameters: none; the ALU opcodes and the instruction-type code come from the shared package.
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- cu_wreg, cu_m2reg, cu_wmem, cu_branch  in  1 each  decoded control from decode stage
- cu_shift  in  1  operand A is the shift amount
- cu_aluimm  in  1  operand B is the immediate
- cu_regrt  in  1  destination is rt (else rd)
- cu_aluc  in  4  ALU opcode
- id_pc4, id_inA, id_inB, id_imm  in  32 each  PC+4, rs data, rt data, extended immediate
- rt, rd  in  5 each  register specifiers
- ID_ins_type, ID_ins_number  in  4 each  debug tags
- ex_wreg, ex_m2reg, ex_wmem  out  1 each  registered control to memory stage
- ex_aluR  out  32  ALU result
- ex_inB  out  32  registered rt data (store data)
- ex_destR  out  5  destination register
- ex_zero  out  1  ex_aluR == 0
- ex_btaken  out  1  branch taken
- ex_btarget  out  32  branch target
- EX_ins_type, EX_ins_number  out  4 each  registered tags
- ex_ovf  out  1  sticky overflow flag; present only with EX_OVF_EN

## Operation
- ID/EX register captures every input on every posedge. There is no enable and no stall input: decode inserts its own bubbles as an all-zero instruction, which arrives here as all-zero control.
- Operand A = cu_shift ? {27'b0, imm[10:6]} : inA.
- Operand B = cu_aluimm ? imm : inB. "imm", "inA" and "inB" here are the registered copies.
- ALU opcodes, all 32-bit wrap-around:
  - ADD 0000, SUB 0001 (result = A − B), AND 0010, OR 0011, XOR 0100, NOR 0101
  - SLT 0110: signed compare, result 1 or 0
  - SLL 0111, SRL 1000, SRA 1001: shift B by A[4:0]
  - LUI 1010: result = {B[15:0], 16'b0}
  - Codes 1011–1111: result 0
- ex_destR = cu_regrt ? rt : rd, from the registered values.
- ex_btarget = pc4 + (imm << 2), truncated to 32 bits.
- ex_btaken = branch & ex_zero.
- Control outputs pass straight through from the register.
- Reset values:
  - all control outputs, ex_aluR inputs and ex_inB: 0
  - registered pc4: 32'hFFFF_FFFF
  - registered imm: 0
  - EX_ins_type: INST_TYPE_NONE; EX_ins_number: 0
  - ex_btaken: 0
- Reset asserted mid-stream discards the instruction in EX. The first post-reset cycle presents a bubble.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on every output after edge N, with combinational ALU and branch logic fed from the register.
- Every output is a function of register state only. There is no combinational path from any input to any output.
- Back-to-back instructions occur every cycle. A bubble produces wreg=wmem=branch=0 and ex_btaken=0.
- rst and valid inputs in the same cycle: rst wins.

## Configuration
- EX_OVF_EN defined:
  - Signed overflow on ADD or SUB forces ex_wreg=0 for that instruction.
  - The same overflow sets ex_ovf on the next edge.
  - ex_ovf stays set until rst.
- EX_OVF_EN undefined:
  - No ex_ovf port.
  - ADD and SUB wrap silently; ex_wreg is unaffected.

## Structure
- Shared package (`cpu_defs`):
  - ALU opcode constants ALU_ADD … ALU_LUI
  - INST_TYPE_NONE, also used by the decode stage
- One sub-module, `alu`: purely combinational (a, b, aluc → result, zero, ovf). The stage module holds the ID/EX register, operand muxes, destination mux and branch logic.

## Test plan
- Reset: hold rst with nonzero inputs → all outputs 0, EX_ins_type=NONE, ex_btarget = 32'hFFFF_FFFF + 0.
- ADD immediate: inA=5, imm=32'hFFFF_FFFD, aluimm=1, aluc=ADD, regrt=1, rt=9 → next cycle ex_aluR=2, ex_destR=9.
- Shifts: shift=1, imm[10:6]=4, inB=32'h8000_0000 → SRA gives 32'hF800_0000, SRL gives 32'h0800_0000.
- Branch: branch=1, aluc=SUB, inA=inB=7, pc4=32'h100, imm=3 → ex_zero=1, ex_btaken=1, ex_btarget=32'h10C. Repeat with inB=8 → ex_btaken=0.
- Bubble then reset: all-zero input cycle → ex_wreg=ex_wmem=ex_btaken=0. Assert rst one cycle mid-stream → that instruction is dropped.
- With EX_OVF_EN: ADD 32'h7FFF_FFFF + 1 with wreg=1 → ex_aluR=32'h8000_0000, ex_wreg=0, ex_ovf=1 and held through later instructions until rst.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared CPU definitions: ALU opcodes, instruction-type tags, ID/EX control bundle
//
// Contents:
//   alu_op_e        4-bit ALU opcodes ALU_ADD .. ALU_LUI (codes 1011-1111 unused, ALU yields 0)
//   INST_TYPE_NONE  instruction-type tag for "no instruction" (also used by decode)
//   ctrl_t          decoded control bits carried through the ID/EX register
package cpu_defs;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOR = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_SRA = 4'b1001,
    ALU_LUI = 4'b1010
  } alu_op_e;

  localparam logic [3:0] INST_TYPE_NONE = 4'd0;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       branch;
    logic       shift;
    logic       aluimm;
    logic       regrt;
    logic [3:0] aluc;
  } ctrl_t;

endpackage

// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - combinational 32-bit ALU for the execute stage
//
// Ports:
//   i_a, i_b   32  operands (shifts move i_b by i_a[4:0])
//   i_aluc      4  opcode from cpu_defs::alu_op_e
//   o_result   32  wrap-around result; unused opcodes give 0
//   o_zero      1  o_result == 0
//   o_ovf       1  signed overflow of ADD/SUB, 0 for every other opcode
module alu
  import cpu_defs::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_aluc,
  output logic [31:0] o_result,
  output logic        o_zero,
  output logic        o_ovf
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_result;
  logic        w_ovf;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  always_comb begin
    w_result = 32'd0;
    w_ovf    = 1'b0;
    case (i_aluc)
      ALU_ADD: begin
        w_result = w_sum;
        // Same-sign operands producing an opposite-sign sum.
        w_ovf    = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
      end
      ALU_SUB: begin
        w_result = w_diff;
        // Opposite-sign operands where the difference takes B's sign.
        w_ovf    = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
      end
      ALU_AND: w_result = i_a & i_b;
      ALU_OR:  w_result = i_a | i_b;
      ALU_XOR: w_result = i_a ^ i_b;
      ALU_NOR: w_result = ~(i_a | i_b);
      ALU_SLT: w_result = {31'd0, ($signed(i_a) < $signed(i_b))};
      ALU_SLL: w_result = i_b << i_a[4:0];
      ALU_SRL: w_result = i_b >> i_a[4:0];
      ALU_SRA: w_result = $unsigned($signed(i_b) >>> i_a[4:0]);
      ALU_LUI: w_result = {i_b[15:0], 16'd0};
      default: w_result = 32'd0;
    endcase
  end

  assign o_result = w_result;
  assign o_zero   = (w_result == 32'd0);
  assign o_ovf    = w_ovf;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ID/EX register, operand/destination muxes, ALU, branch resolve
//
// Optional feature: define EX_OVF_EN to add the sticky ex_ovf output and suppress
// the register write of an ADD/SUB that overflows.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   cu_*                          decoded control from decode
//   id_pc4, id_inA, id_inB, id_imm  PC+4, rs data, rt data, extended immediate
//   rt, rd                        register specifiers
//   ID_ins_type, ID_ins_number    debug tags
//   ex_wreg, ex_m2reg, ex_wmem    registered control to memory stage
//   ex_aluR, ex_inB, ex_destR     ALU result, store data, destination register
//   ex_zero, ex_btaken, ex_btarget  zero flag, branch decision, branch target
//   EX_ins_type, EX_ins_number    registered debug tags
//   ex_ovf                        sticky overflow (EX_OVF_EN only)
module ex_stage
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_wreg,
  input  logic        cu_m2reg,
  input  logic        cu_wmem,
  input  logic        cu_branch,
  input  logic        cu_shift,
  input  logic        cu_aluimm,
  input  logic        cu_regrt,
  input  logic [3:0]  cu_aluc,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_inA,
  input  logic [31:0] id_inB,
  input  logic [31:0] id_imm,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [3:0]  ID_ins_type,
  input  logic [3:0]  ID_ins_number,
  output logic        ex_wreg,
  output logic        ex_m2reg,
  output logic        ex_wmem,
  output logic [31:0] ex_aluR,
  output logic [31:0] ex_inB,
  output logic [4:0]  ex_destR,
  output logic        ex_zero,
  output logic        ex_btaken,
  output logic [31:0] ex_btarget,
  output logic [3:0]  EX_ins_type,
  output logic [3:0]  EX_ins_number
`ifdef EX_OVF_EN
  ,
  output logic        ex_ovf
`endif
);

  ctrl_t       r_ctrl;
  logic [31:0] r_pc4;
  logic [31:0] r_inA;
  logic [31:0] r_inB;
  logic [31:0] r_imm;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [3:0]  r_type;
  logic [3:0]  r_num;

  logic [31:0] w_opa;
  logic [31:0] w_opb;
  logic [31:0] w_alu_result;
  logic        w_alu_zero;

  // No enable: decode inserts bubbles as all-zero instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_pc4  <= 32'hFFFF_FFFF;
      r_inA  <= 32'd0;
      r_inB  <= 32'd0;
      r_imm  <= 32'd0;
      r_rt   <= 5'd0;
      r_rd   <= 5'd0;
      r_type <= INST_TYPE_NONE;
      r_num  <= 4'd0;
    end else begin
      r_ctrl <= '{wreg: cu_wreg, m2reg: cu_m2reg, wmem: cu_wmem, branch: cu_branch,
                  shift: cu_shift, aluimm: cu_aluimm, regrt: cu_regrt, aluc: cu_aluc};
      r_pc4  <= id_pc4;
      r_inA  <= id_inA;
      r_inB  <= id_inB;
      r_imm  <= id_imm;
      r_rt   <= rt;
      r_rd   <= rd;
      r_type <= ID_ins_type;
      r_num  <= ID_ins_number;
    end
  end

  // Shift amount lives in the shamt field of the immediate.
  assign w_opa = r_ctrl.shift  ? {27'd0, r_imm[10:6]} : r_inA;
  assign w_opb = r_ctrl.aluimm ? r_imm : r_inB;

`ifdef EX_OVF_EN
  logic w_alu_ovf;
  logic r_ovf;
`else
  logic w_unused_ovf;
`endif

  alu u_alu (
    .i_a      (w_opa),
    .i_b      (w_opb),
    .i_aluc   (r_ctrl.aluc),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero),
`ifdef EX_OVF_EN
    .o_ovf    (w_alu_ovf)
`else
    .o_ovf    (w_unused_ovf)
`endif
  );

`ifdef EX_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_alu_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign ex_ovf  = r_ovf;
  // An overflowing ADD/SUB must not commit its result.
  assign ex_wreg = r_ctrl.wreg & ~w_alu_ovf;
`else
  assign ex_wreg = r_ctrl.wreg;
`endif

  assign ex_m2reg      = r_ctrl.m2reg;
  assign ex_wmem       = r_ctrl.wmem;
  assign ex_aluR       = w_alu_result;
  assign ex_zero       = w_alu_zero;
  assign ex_inB        = r_inB;
  assign ex_destR      = r_ctrl.regrt ? r_rt : r_rd;
  assign ex_btaken     = r_ctrl.branch & w_alu_zero;
  assign ex_btarget    = r_pc4 + {r_imm[29:0], 2'b00};
  assign EX_ins_type   = r_type;
  assign EX_ins_number = r_num;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking scoreboard bench for ex_stage
module tb_ex_stage;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cu_wreg, cu_m2reg, cu_wmem, cu_branch, cu_shift, cu_aluimm, cu_regrt;
  logic [3:0]  cu_aluc;
  logic [31:0] id_pc4, id_inA, id_inB, id_imm;
  logic [4:0]  rt, rd;
  logic [3:0]  ID_ins_type, ID_ins_number;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_zero, ex_btaken;
  logic [31:0] ex_aluR, ex_inB, ex_btarget;
  logic [4:0]  ex_destR;
  logic [3:0]  EX_ins_type, EX_ins_number;
`ifdef EX_OVF_EN
  logic        ex_ovf;
`endif

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .cu_wreg(cu_wreg), .cu_m2reg(cu_m2reg), .cu_wmem(cu_wmem), .cu_branch(cu_branch),
    .cu_shift(cu_shift), .cu_aluimm(cu_aluimm), .cu_regrt(cu_regrt), .cu_aluc(cu_aluc),
    .id_pc4(id_pc4), .id_inA(id_inA), .id_inB(id_inB), .id_imm(id_imm),
    .rt(rt), .rd(rd), .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
    .ex_zero(ex_zero), .ex_btaken(ex_btaken), .ex_btarget(ex_btarget),
    .EX_ins_type(EX_ins_type), .EX_ins_number(EX_ins_number)
`ifdef EX_OVF_EN
    , .ex_ovf(ex_ovf)
`endif
  );

  typedef struct {
    logic        wreg, m2reg, wmem, branch, shift, aluimm, regrt;
    logic [3:0]  aluc;
    logic [31:0] pc4, inA, inB, imm;
    logic [4:0]  rt, rd;
    logic [3:0]  typ, num;
  } in_t;

  typedef struct {
    logic        wreg, m2reg, wmem, zero, btaken;
    logic [31:0] aluR, inB, btarget;
    logic [4:0]  destR;
    logic [3:0]  typ, num;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.wreg = 0; e.m2reg = 0; e.wmem = 0; e.btaken = 0;
    e.aluR = 0; e.zero = 1; e.inB = 0; e.destR = 0;
    e.btarget = 32'hFFFF_FFFF; e.typ = INST_TYPE_NONE; e.num = 0;
    return e;
  endfunction

  function automatic exp_t model(input in_t x);
    exp_t        e;
    logic [31:0] a, b, r;
    logic        ovf;
    a = x.shift ? {27'd0, x.imm[10:6]} : x.inA;
    b = x.aluimm ? x.imm : x.inB;
    ovf = 0;
    case (x.aluc)
      4'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b);
      4'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: r = b << a[4:0];
      4'd8: r = b >> a[4:0];
      4'd9: r = $unsigned($signed(b) >>> a[4:0]);
      4'd10: r = {b[15:0], 16'd0};
      default: r = 0;
    endcase
    e.aluR = r;
    e.zero = (r == 0);
`ifdef EX_OVF_EN
    e.wreg = x.wreg & ~ovf;
`else
    e.wreg = x.wreg;
`endif
    e.m2reg = x.m2reg; e.wmem = x.wmem;
    e.btaken = x.branch & e.zero;
    e.inB = x.inB;
    e.destR = x.regrt ? x.rt : x.rd;
    e.btarget = x.pc4 + (x.imm << 2);
    e.typ = x.typ; e.num = x.num;
    return e;
  endfunction

  task automatic step(input string tag, input in_t x, input logic do_rst);
    exp_t e;
    rst = do_rst;
    cu_wreg = x.wreg; cu_m2reg = x.m2reg; cu_wmem = x.wmem; cu_branch = x.branch;
    cu_shift = x.shift; cu_aluimm = x.aluimm; cu_regrt = x.regrt; cu_aluc = x.aluc;
    id_pc4 = x.pc4; id_inA = x.inA; id_inB = x.inB; id_imm = x.imm;
    rt = x.rt; rd = x.rd; ID_ins_type = x.typ; ID_ins_number = x.num;
    q.push_back(do_rst ? reset_exp() : model(x));
    @(posedge clk);
    #1;
    n_checks++;
    assert (q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".aluR"},    ex_aluR,    e.aluR);
      chk({tag, ".zero"},    ex_zero,    e.zero);
      chk({tag, ".wreg"},    ex_wreg,    e.wreg);
      chk({tag, ".m2reg"},   ex_m2reg,   e.m2reg);
      chk({tag, ".wmem"},    ex_wmem,    e.wmem);
      chk({tag, ".btaken"},  ex_btaken,  e.btaken);
      chk({tag, ".btarget"}, ex_btarget, e.btarget);
      chk({tag, ".inB"},     ex_inB,     e.inB);
      chk({tag, ".destR"},   ex_destR,   e.destR);
      chk({tag, ".type"},    EX_ins_type, e.typ);
      chk({tag, ".num"},     EX_ins_number, e.num);
    end
  endtask

  initial begin
    in_t x;
    in_t z;
    z = '{default: 0};

    // Reset with busy inputs, held two cycles.
    x = z; x.wreg = 1; x.m2reg = 1; x.wmem = 1; x.branch = 1; x.aluc = 4'd3;
    x.pc4 = 32'h40; x.inA = 32'h55; x.inB = 32'hAA; x.imm = 32'h7; x.rt = 3; x.rd = 4;
    x.typ = 4'd5; x.num = 4'd9;
    step("reset0", x, 1);
    step("reset1", x, 1);

    x = z; x.wreg = 1; x.aluimm = 1; x.regrt = 1; x.rt = 9; x.rd = 2;
    x.inA = 5; x.imm = 32'hFFFF_FFFD; x.aluc = 4'd0; x.pc4 = 32'h8; x.typ = 4'd1; x.num = 4'd1;
    step("addi", x, 0);

    x = z; x.wreg = 1; x.shift = 1; x.imm = 32'd4 << 6; x.inB = 32'h8000_0000;
    x.aluc = 4'd9; x.rd = 7; x.typ = 4'd2; x.num = 4'd2;
    step("sra", x, 0);
    x.aluc = 4'd8; x.num = 4'd3;
    step("srl", x, 0);
    x.aluc = 4'd7; x.inB = 32'h0000_0001; x.num = 4'd4;
    step("sll", x, 0);

    x = z; x.branch = 1; x.aluc = 4'd1; x.inA = 7; x.inB = 7; x.pc4 = 32'h100; x.imm = 3;
    x.typ = 4'd3; x.num = 4'd5;
    step("beq_taken", x, 0);
    x.inB = 8; x.num = 4'd6;
    step("beq_not", x, 0);

    step("bubble", z, 0);

    x = z; x.wreg = 1; x.inA = 32'hF0F0_1234; x.inB = 32'h0FF0_FF00; x.rd = 12;
    x.aluc = 4'd2; step("and", x, 0);
    x.aluc = 4'd3; step("or", x, 0);
    x.aluc = 4'd4; step("xor", x, 0);
    x.aluc = 4'd5; step("nor", x, 0);
    x.aluc = 4'd6; x.inA = 32'hFFFF_FFFD; x.inB = 2; step("slt_neg", x, 0);
    x.inA = 2; x.inB = 32'hFFFF_FFFD; step("slt_pos", x, 0);

    x = z; x.wreg = 1; x.aluimm = 1; x.regrt = 1; x.rt = 31; x.imm = 32'h0000_1234;
    x.aluc = 4'd10; step("lui", x, 0);

    // Unused opcode yields 0, so a branch with it resolves taken.
    x = z; x.branch = 1; x.aluc = 4'd11; x.inA = 32'h1; x.inB = 32'h2;
    x.pc4 = 32'h200; x.imm = 32'hFFFF_FFFF; step("op1011", x, 0);

    x = z; x.wmem = 1; x.aluimm = 1; x.inA = 32'h1000; x.imm = 32'h10;
    x.inB = 32'hDEAD_BEEF; x.aluc = 4'd0; x.typ = 4'd7; x.num = 4'd10;
    step("store", x, 0);

    // Mid-stream reset discards the instruction in flight.
    x = z; x.wreg = 1; x.m2reg = 1; x.inA = 3; x.inB = 4; x.rd = 5; x.typ = 4'd4; x.num = 4'd11;
    step("midrst", x, 1);
    x.num = 4'd12;
    step("after_rst", x, 0);

`ifdef EX_OVF_EN
    chk("ovf_clear", ex_ovf, 1'b0);
    x = z; x.wreg = 1; x.inA = 32'h7FFF_FFFF; x.inB = 1; x.rd = 6; x.aluc = 4'd0;
    step("ovf_add", x, 0);
    chk("ovf_not_yet", ex_ovf, 1'b0);
    x = z; x.wreg = 1; x.inA = 1; x.inB = 1; x.rd = 6;
    step("post_ovf1", x, 0);
    chk("ovf_set", ex_ovf, 1'b1);
    step("post_ovf2", x, 0);
    chk("ovf_held", ex_ovf, 1'b1);
    x = z; x.wreg = 1; x.inA = 32'h8000_0000; x.inB = 1; x.aluc = 4'd1; x.rd = 8;
    step("ovf_sub", x, 0);
    step("ovf_rst", z, 1);
    chk("ovf_cleared", ex_ovf, 1'b0);
`endif

    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
